// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared encodings for the memory-access stage: write-back source
//            select, load/store funct3 size codes, memory FSM state type and a
//            byte-enable helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Write-back source select (wbsel)
    localparam logic [1:0] c_WB_MEM = 2'b00;
    localparam logic [1:0] c_WB_ALU = 2'b01;
    localparam logic [1:0] c_WB_PC4 = 2'b10;

    // Load/store size and sign codes (funct3)
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10
    } memState_t;

    // Byte lanes touched by an access. funct3[1:0] carries the size for both
    // signed and unsigned variants; the low address bits are already
    // aligned for the size by the caller.
    function automatic logic [3:0] byteEnable(input logic [2:0] funct3,
                                              input logic [1:0] addrLo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addrLo;
            2'b01:   be = 4'b0011 << addrLo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Extracts the addressed byte/halfword/word from a 32-bit read
//            word and sign- or zero-extends it according to funct3.
// Ports    : rdata    - raw word returned by data memory
//            addrLo   - byte offset within the word (size-aligned)
//            funct3   - load size/sign code
//            loadData - aligned, extended load value
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [2:0]  funct3,
    output logic [31:0] loadData
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = rdata >> {addrLo, 3'b000};
        case (funct3)
            c_F3_B:  loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_F3_H:  loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_F3_BU: loadData = {24'h0, w_shifted[7:0]};
            c_F3_HU: loadData = {16'h0, w_shifted[15:0]};
            default: loadData = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM stage of the five-stage RISC-V pipeline. Issues loads and
//            stores on a valid/ready data-memory channel, stalls the front of
//            the pipeline while an access is outstanding and holds the MEM/WB
//            register that feeds write-back and forwarding.
// Ports    : clk, rst_n                        - clock, async active-low reset
//            regwriteM..pc4M                   - EX/MEM pipeline fields
//            dmem_req/we/be/addr/wdata         - memory request channel
//            dmem_ready                        - request accepted
//            dmem_rvalid, dmem_rdata           - load response strobe/data
//            stallM                            - freezes PC..EX/MEM
//            regwriteW..resultW                - MEM/WB fields and result
//            misalignM                         - misaligned-access pulse
// Config   : MEM_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses are
//            dropped and flagged on misalignM; otherwise the offending low
//            address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regwriteM,
    input  logic        memreadM,
    input  logic        memrwM,
    input  logic [1:0]  wbselM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  rdM,
    input  logic [31:0] ALUresM,
    input  logic [31:0] data_writeM,
    input  logic [31:0] pc4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic        regwriteW,
    output logic [1:0]  wbselW,
    output logic [4:0]  rdW,
    output logic [31:0] ALUresW,
    output logic [31:0] read_dataW,
    output logic [31:0] pc4W,
    output logic [31:0] resultW
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalignM
`endif
);

    memState_t   r_state;
    memState_t   w_stateNext;

    logic        w_isStore;
    logic        w_isLoad;
    logic        w_memOp;
    logic        w_sizeH;
    logic        w_sizeW;
    logic        w_misalign;
    logic        w_access;
    logic [1:0]  w_addrLo;
    logic        w_req;
    logic        w_done;
    logic        w_stall;
    logic [31:0] w_wdataFmt;
    logic [31:0] w_loadData;

    // A store takes priority if both strobes are ever raised together.
    assign w_isStore = memrwM;
    assign w_isLoad  = memreadM & ~memrwM;
    assign w_memOp   = w_isStore | w_isLoad;
    assign w_sizeH   = (funct3M[1:0] == 2'b01);
    assign w_sizeW   = funct3M[1];

    // Low address bits forced to the natural alignment of the access size.
    assign w_addrLo = w_sizeW ? 2'b00 :
                      w_sizeH ? {ALUresM[1], 1'b0} : ALUresM[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_memOp & ((w_sizeH & ALUresM[0]) |
                                   (w_sizeW & (|ALUresM[1:0])));
    assign misalignM  = rst_n & w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_access = w_memOp & ~w_misalign;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_req       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Request goes out in the same cycle the instruction arrives.
                if (w_access) begin
                    w_req = 1'b1;
                    if (dmem_ready) begin
                        if (w_isStore) begin
                            w_done = 1'b1;
                        end else begin
                            w_stateNext = S_RESP;
                        end
                    end else begin
                        w_stateNext = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (dmem_ready) begin
                    if (w_isStore) begin
                        w_done      = 1'b1;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (dmem_rvalid) begin
                    w_done      = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign w_stall = w_access & ~w_done;

    // Outputs are gated with rst_n so an access is dropped the instant reset
    // asserts, even while EX/MEM still presents a memory instruction.
    assign stallM = rst_n & w_stall;

    // ------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------
    always_comb begin
        case (funct3M[1:0])
            2'b00:   w_wdataFmt = {4{data_writeM[7:0]}};
            2'b01:   w_wdataFmt = {2{data_writeM[15:0]}};
            default: w_wdataFmt = data_writeM;
        endcase
    end

    assign dmem_req   = rst_n & w_req;
    assign dmem_we    = dmem_req & w_isStore;
    assign dmem_be    = dmem_req ? byteEnable(funct3M, w_addrLo) : 4'b0000;
    assign dmem_addr  = dmem_req ? {ALUresM[31:2], 2'b00} : 32'h0;
    assign dmem_wdata = dmem_req ? w_wdataFmt : 32'h0;

    load_align u_loadAlign (
        .rdata    (dmem_rdata),
        .addrLo   (w_addrLo),
        .funct3   (funct3M),
        .loadData (w_loadData)
    );

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwriteW  <= 1'b0;
            wbselW     <= 2'b00;
            rdW        <= 5'd0;
            ALUresW    <= 32'h0;
            read_dataW <= 32'h0;
            pc4W       <= 32'h0;
        end else if (!w_stall) begin
            regwriteW  <= regwriteM & ~w_misalign;
            wbselW     <= wbselM;
            rdW        <= rdM;
            ALUresW    <= ALUresM;
            pc4W       <= pc4M;
            // Only a completing load captures memory data; stray strobes
            // during non-load cycles never leak into write-back.
            read_dataW <= (w_isLoad & w_done) ? w_loadData : 32'h0;
        end else begin
            // Bubble into WB while the access is outstanding.
            regwriteW  <= 1'b0;
        end
    end

    always_comb begin
        case (wbselW)
            c_WB_MEM: resultW = read_dataW;
            c_WB_ALU: resultW = ALUresW;
            c_WB_PC4: resultW = pc4W;
            default:  resultW = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. Expected requests and
//            write-backs are queued at issue time; a monitor pops and
//            compares them whenever the DUT accepts a request or writes back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] rdata;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwriteM, memreadM, memrwM;
    logic [1:0]  wbselM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] ALUresM, data_writeM, pc4M;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stallM, regwriteW;
    logic [1:0]  wbselW;
    logic [4:0]  rdW;
    logic [31:0] ALUresW, read_dataW, pc4W, resultW;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalignM;
`endif

    int   nTests = 0;
    int   nFail  = 0;
    int   misCnt = 0;
    int   st;
    req_t reqQ[$];
    wb_t  wbQ[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n),
        .regwriteM(regwriteM), .memreadM(memreadM), .memrwM(memrwM),
        .wbselM(wbselM), .funct3M(funct3M), .rdM(rdM),
        .ALUresM(ALUresM), .data_writeM(data_writeM), .pc4M(pc4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stallM(stallM), .regwriteW(regwriteW), .wbselW(wbselW), .rdW(rdW),
        .ALUresW(ALUresW), .read_dataW(read_dataW), .pc4W(pc4W), .resultW(resultW)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalignM(misalignM)
`endif
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares every accepted request and every write-back.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dmem_req && dmem_ready) begin
                if (reqQ.size() == 0) begin
                    check("unexpected_req_addr", dmem_addr, 32'hxxxx_xxxx);
                end else begin
                    req_t e;
                    e = reqQ.pop_front();
                    check("req_we",    {31'h0, dmem_we}, {31'h0, e.we});
                    check("req_be",    {28'h0, dmem_be}, {28'h0, e.be});
                    check("req_addr",  dmem_addr,  e.addr);
                    check("req_wdata", dmem_wdata, e.wdata);
                end
            end
            if (regwriteW) begin
                if (wbQ.size() == 0) begin
                    check("unexpected_wb_rd", {27'h0, rdW}, 32'hxxxx_xxxx);
                end else begin
                    wb_t w;
                    w = wbQ.pop_front();
                    check("wb_rd",        {27'h0, rdW}, {27'h0, w.rd});
                    check("wb_resultW",   resultW,    w.result);
                    check("wb_read_data", read_dataW, w.rdata);
                end
            end
`ifdef MEM_MISALIGN_TRAP_EN
            if (misalignM) misCnt++;
`endif
        end
    end

    task automatic setNop();
        regwriteM = 0; memreadM = 0; memrwM = 0; wbselM = 2'b01; funct3M = 3'b000;
        rdM = 0; ALUresM = 0; data_writeM = 0; pc4M = 0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    // Present one instruction in MEM and act as memory until it leaves MEM.
    // readyLow: cycles of ready=0 before accept; rvDelay: rvalid cycles after accept.
    task automatic runMem(input logic rw, input logic ld, input logic sto,
                          input logic [1:0] wb, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4,
                          input int readyLow, input int rvDelay,
                          input logic [31:0] rdata, output int stalls);
        int   acc;
        logic stl;
        bit   fin;
        regwriteM = rw; memreadM = ld; memrwM = sto; wbselM = wb; funct3M = f3;
        rdM = rd; ALUresM = alu; data_writeM = wd; pc4M = pc4; dmem_rdata = rdata;
        stalls = 0; acc = -1; fin = 0;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            dmem_ready  = (cyc >= readyLow);
            dmem_rvalid = (acc >= 0) && (cyc == acc + rvDelay);
            @(negedge clk);
            if (acc < 0 && dmem_req && dmem_ready) acc = cyc;
            stl = stallM;
            if (stl) begin
                stalls++;
                if (cyc > 0) check("bubble_regwriteW", {31'h0, regwriteW}, 32'h0);
            end
            @(posedge clk); #1;
            if (!stl) fin = 1;
        end
        if (!fin) check("timeout_stallM", 32'h1, 32'h0);
        setNop();
    endtask

    initial begin
        setNop();
        rst_n = 0;
        memrwM = 1; ALUresM = 32'h100; dmem_ready = 1;   // gating under reset
        #2;
        check("rst_dmem_req",  {31'h0, dmem_req}, 32'h0);
        check("rst_stallM",    {31'h0, stallM},   32'h0);
        check("rst_regwriteW", {31'h0, regwriteW}, 32'h0);
        check("rst_resultW",   resultW, 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        setNop();
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;

        // ALU and pc+4 write-back, no memory access
        wbQ.push_back('{rd: 5'd5, result: 32'h0000_1234, rdata: 32'h0});
        runMem(1, 0, 0, 2'b01, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h4000, 0, 1, 32'h0, st);
        check("alu_stalls", st, 0);
        wbQ.push_back('{rd: 5'd1, result: 32'h0000_4004, rdata: 32'h0});
        runMem(1, 0, 0, 2'b10, 3'b000, 5'd1, 32'h55, 32'h0, 32'h4004, 0, 1, 32'h0, st);
        check("pc4_stalls", st, 0);

        // SW 0x100
        reqQ.push_back('{we: 1'b1, be: 4'b1111, addr: 32'h100, wdata: 32'hDEADBEEF});
        runMem(0, 0, 1, 2'b01, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 32'h0, st);
        check("sw_stalls", st, 0);

        // LB 0x103
        reqQ.push_back('{we: 1'b0, be: 4'b1000, addr: 32'h100, wdata: 32'h0});
        wbQ.push_back('{rd: 5'd3, result: 32'hFFFFFF80, rdata: 32'hFFFFFF80});
        runMem(1, 1, 0, 2'b00, 3'b000, 5'd3, 32'h103, 32'h0, 32'h0, 0, 1, 32'h80FFFF7F, st);
        check("lb_stalls", st, 1);

        // LHU 0x102, ready low 3 cycles, rvalid 2 cycles after accept
        reqQ.push_back('{we: 1'b0, be: 4'b1100, addr: 32'h100, wdata: 32'h0});
        wbQ.push_back('{rd: 5'd4, result: 32'h000080FF, rdata: 32'h000080FF});
        runMem(1, 1, 0, 2'b00, 3'b101, 5'd4, 32'h102, 32'h0, 32'h0, 3, 2, 32'h80FF1234, st);
        check("lhu_stalls", st, 5);

        // SB 0x201
        reqQ.push_back('{we: 1'b1, be: 4'b0010, addr: 32'h200, wdata: 32'hABABABAB});
        runMem(0, 0, 1, 2'b01, 3'b000, 5'd0, 32'h201, 32'h000000AB, 32'h0, 0, 1, 32'h0, st);
        check("sb_stalls", st, 0);

        // SH 0x302, ready low 2 cycles
        reqQ.push_back('{we: 1'b1, be: 4'b1100, addr: 32'h300, wdata: 32'hCAFECAFE});
        runMem(0, 0, 1, 2'b01, 3'b001, 5'd0, 32'h302, 32'h0000CAFE, 32'h0, 2, 1, 32'h0, st);
        check("sh_stalls", st, 2);

        // LH 0x100 sign-extended
        reqQ.push_back('{we: 1'b0, be: 4'b0011, addr: 32'h100, wdata: 32'h0});
        wbQ.push_back('{rd: 5'd6, result: 32'hFFFF8001, rdata: 32'hFFFF8001});
        runMem(1, 1, 0, 2'b00, 3'b001, 5'd6, 32'h100, 32'h0, 32'h0, 0, 1, 32'h00008001, st);
        check("lh_stalls", st, 1);

        // LBU 0x101, rvalid 2 cycles after accept
        reqQ.push_back('{we: 1'b0, be: 4'b0010, addr: 32'h100, wdata: 32'h0});
        wbQ.push_back('{rd: 5'd8, result: 32'h0000009A, rdata: 32'h0000009A});
        runMem(1, 1, 0, 2'b00, 3'b100, 5'd8, 32'h101, 32'h0, 32'h0, 0, 2, 32'h00009A00, st);
        check("lbu_stalls", st, 2);

        // LW 0x102 (misaligned)
`ifdef MEM_MISALIGN_TRAP_EN
        runMem(1, 1, 0, 2'b00, 3'b010, 5'd9, 32'h102, 32'h0, 32'h0, 0, 1, 32'h11223344, st);
        check("lw_mis_stalls", st, 0);
        @(negedge clk);
        check("lw_mis_pulses", misCnt, 1);
        check("lw_mis_regwriteW", {31'h0, regwriteW}, 32'h0);
        @(posedge clk); #1;
`else
        reqQ.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h100, wdata: 32'h0});
        wbQ.push_back('{rd: 5'd9, result: 32'h11223344, rdata: 32'h11223344});
        runMem(1, 1, 0, 2'b00, 3'b010, 5'd9, 32'h102, 32'h0, 32'h0, 0, 1, 32'h11223344, st);
        check("lw_unal_stalls", st, 1);
`endif

        // Leave non-zero MEM/WB fields, then reset during RESP
        wbQ.push_back('{rd: 5'd10, result: 32'h0000_0777, rdata: 32'h0});
        runMem(1, 0, 0, 2'b01, 3'b000, 5'd10, 32'h777, 32'h0, 32'h8, 0, 1, 32'h0, st);
        regwriteM = 1; memreadM = 1; funct3M = 3'b010; rdM = 5'd7; wbselM = 2'b00;
        ALUresM = 32'h400; pc4M = 32'h44; dmem_ready = 1;
        reqQ.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h400, wdata: 32'h0});
        @(negedge clk);
        @(posedge clk); #1;
        dmem_ready = 0;
        #1;
        check("resp_stallM",   {31'h0, stallM},   32'h1);
        check("resp_dmem_req", {31'h0, dmem_req}, 32'h0);
        rst_n = 0;
        #1;
        check("rstmid_dmem_req",   {31'h0, dmem_req},  32'h0);
        check("rstmid_stallM",     {31'h0, stallM},    32'h0);
        check("rstmid_rdW",        {27'h0, rdW},       32'h0);
        check("rstmid_ALUresW",    ALUresW,    32'h0);
        check("rstmid_pc4W",       pc4W,       32'h0);
        check("rstmid_read_dataW", read_dataW, 32'h0);
        @(posedge clk); #1;
        setNop();
        rst_n = 1;
        dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;   // late response
        @(negedge clk);
        check("late_rv_stallM",   {31'h0, stallM},   32'h0);
        check("late_rv_dmem_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 0;
        @(negedge clk);
        check("late_rv_read_dataW", read_dataW, 32'h0);
        check("late_rv_regwriteW",  {31'h0, regwriteW}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reqQ_empty", reqQ.size(), 0);
        check("wbQ_empty",  wbQ.size(),  0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
